// File: rtl/freq_edge_counter.sv
// rtl/freq_edge_counter.sv - gated rising-edge counter publishing edges per gate window
module freq_edge_counter #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   gate_tick,
  input  logic                   enable,
  input  logic                   sig_in,
  output logic [COUNT_WIDTH-1:0] freq_out,
  output logic                   freq_valid,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = '0;

  state_t state_q, state_d;

  // Two-flop synchronizer plus one history flop for edge detection
  logic s1_q, s2_q, s2_dly_q;
  logic rise_event;

  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic [COUNT_WIDTH-1:0] freq_q, freq_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  // A rise_event that lands on a window boundary opens the new window at 1
  logic [COUNT_WIDTH-1:0] cnt_restart;

  assign rise_event  = s2_q & ~s2_dly_q;
  assign cnt_restart = {{(COUNT_WIDTH-1){1'b0}}, rise_event};

  // Synchronizer chain runs in every state so edge history is never stale
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s2_dly_q <= 1'b0;
    end else begin
      s1_q     <= sig_in;
      s2_q     <= s1_q;
      s2_dly_q <= s2_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; dropping enable wins over everything else
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    state_d = ST_ARM;
        ST_ARM:     if (gate_tick) state_d = ST_MEASURE;
        ST_MEASURE: state_d = ST_MEASURE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Counter, saturation and result next-state per state
  always_comb begin
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        sat_d = 1'b0;
      end
      ST_ARM: begin
        if (enable && gate_tick) begin
          cnt_d = cnt_restart;
        end else begin
          cnt_d = CNT_ZERO;
        end
        sat_d = 1'b0;
      end
      ST_MEASURE: begin
        if (!enable) begin
          cnt_d = CNT_ZERO;
          sat_d = 1'b0;
        end else if (gate_tick) begin
          freq_d  = cnt_q;
          ovf_d   = sat_q;
          valid_d = 1'b1;
          cnt_d   = cnt_restart;
          sat_d   = 1'b0;
        end else if (rise_event) begin
          if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        cnt_d = CNT_ZERO;
        sat_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; results persist until the next strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= CNT_ZERO;
      sat_q   <= 1'b0;
      freq_q  <= CNT_ZERO;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign freq_out   = freq_q;
  assign freq_valid = valid_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_freq_edge_counter.sv
// tb/tb_freq_edge_counter.sv - scoreboard bench for freq_edge_counter
module tb_freq_edge_counter;

  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gate_tick = 1'b0;
  logic          enable = 1'b1;
  logic          sig_in = 1'b0;
  logic [CW-1:0] freq_out;
  logic          freq_valid;
  logic          overflow;

  freq_edge_counter #(.COUNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gate_tick  (gate_tick),
    .enable     (enable),
    .sig_in     (sig_in),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int f;
    bit o;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   strobes = 0;

  // Reference model state: unbounded window edge count, reported clipped
  int       cyc = 0;
  int       mode = 0;   // 0 idle, 1 armed, 2 measuring
  int       win_edges = 0;
  bit [2:0] hist = '0;  // sig_in as seen 1, 2 and 3 edges ago
  int       held_f = 0;
  bit       held_o = 1'b0;

  always @(posedge clk) begin
    bit   edge_now;
    exp_t e;
    cyc = cyc + 1;
    edge_now = hist[1] & ~hist[2];
    if (!rst_n) begin
      mode      = 0;
      win_edges = 0;
      hist      = '0;
      held_f    = 0;
      held_o    = 1'b0;
    end else begin
      hist = {hist[1:0], sig_in};
      if (!enable) begin
        mode      = 0;
        win_edges = 0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (gate_tick) begin
          mode      = 2;
          win_edges = edge_now ? 1 : 0;
        end
      end else begin
        if (gate_tick) begin
          e.cyc = cyc;
          e.f   = (win_edges > MAXV) ? MAXV : win_edges;
          e.o   = (win_edges > MAXV);
          sbq.push_back(e);
          held_f    = e.f;
          held_o    = e.o;
          win_edges = edge_now ? 1 : 0;
        end else if (edge_now) begin
          win_edges = win_edges + 1;
        end
      end
    end
  end

  // Monitor: strobes are matched against the queue, quiet cycles against held results
  always @(negedge clk) begin
    exp_t e;
    if (freq_valid === 1'b1) begin
      strobes = strobes + 1;
      tests = tests + 1;
      if (sbq.size() == 0) begin
        fails = fails + 1;
        $display("FAIL strobe_unexpected cyc=%0d: freq_out=%0d overflow=%0b, required no strobe",
                 cyc, freq_out, overflow);
      end else begin
        e = sbq.pop_front();
        if (e.cyc != cyc || freq_out !== CW'(e.f) || overflow !== e.o) begin
          fails = fails + 1;
          $display("FAIL strobe cyc=%0d: freq_out=%0d overflow=%0b, required cyc=%0d freq_out=%0d overflow=%0b",
                   cyc, freq_out, overflow, e.cyc, e.f, e.o);
        end
      end
    end else begin
      tests = tests + 1;
      if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        fails = fails + 1;
        $display("FAIL strobe_missing cyc=%0d: freq_valid=%0b, required 1 with freq_out=%0d",
                 cyc, freq_valid, e.f);
      end
      tests = tests + 1;
      if (freq_out !== CW'(held_f) || overflow !== held_o || freq_valid !== 1'b0) begin
        fails = fails + 1;
        $display("FAIL hold cyc=%0d: freq_out=%0d overflow=%0b valid=%0b, required freq_out=%0d overflow=%0b valid=0",
                 cyc, freq_out, overflow, freq_valid, held_f, held_o);
      end
    end
  end

  // Stimulus generator state
  int sig_hi = 5;
  int sig_lo = 5;
  int sig_ph = 0;
  int gate_per = 100;
  int gate_ph = 0;

  task automatic step();
    @(negedge clk);
    if (sig_ph >= sig_hi + sig_lo) sig_ph = 0;
    sig_in = (sig_ph < sig_hi);
    sig_ph = sig_ph + 1;
    if (gate_ph >= gate_per - 1) begin
      gate_tick = 1'b1;
      gate_ph   = 0;
    end else begin
      gate_tick = 1'b0;
      gate_ph   = gate_ph + 1;
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_out(string name, int ef, bit eo);
    tests = tests + 1;
    if (freq_out !== CW'(ef) || overflow !== eo) begin
      fails = fails + 1;
      $display("FAIL %s: freq_out=%0d overflow=%0b, required freq_out=%0d overflow=%0b",
               name, freq_out, overflow, ef, eo);
    end
  endtask

  initial begin
    // Reset, then basic 10-edge windows
    rst_n = 1'b0;
    enable = 1'b1;
    run(3);
    rst_n = 1'b1;
    run(620);
    check_out("basic_period10", 10, 1'b0);

    // Saturation with fast input, then recovery with slow input
    sig_hi = 2; sig_lo = 2; sig_ph = 0;
    run(320);
    check_out("saturate", MAXV, 1'b1);
    sig_hi = 10; sig_lo = 10; sig_ph = 0;
    run(320);
    check_out("slow_after_sat", 5, 1'b0);

    // Abort mid-window, results must hold, re-arm and report again
    run(37);
    enable = 1'b0;
    run(30);
    check_out("abort_hold", 5, 1'b0);
    enable = 1'b1;
    run(330);
    check_out("reenable", 5, 1'b0);

    // Single-cycle reset mid-window
    run(41);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_out("reset_outputs", 0, 1'b0);
    tests = tests + 1;
    if (freq_valid !== 1'b0) begin
      fails = fails + 1;
      $display("FAIL reset_valid: freq_valid=%0b, required 0", freq_valid);
    end
    run(250);

    // Boundary alignment: odd periods so edges repeatedly coincide with ticks
    gate_per = 97; sig_hi = 5; sig_lo = 5;
    run(600);

    // Idle insensitivity, then enable
    enable = 1'b0;
    gate_per = 50; sig_hi = 3; sig_lo = 4;
    run(300);
    enable = 1'b1;
    run(300);

    // Randomized segments: back-to-back ticks, enable drops, stray resets
    for (int seg = 0; seg < 8; seg++) begin
      gate_per = $urandom_range(1, 60);
      sig_hi   = $urandom_range(2, 7);
      sig_lo   = $urandom_range(2, 7);
      for (int i = 0; i < 300; i++) begin
        step();
        if ($urandom_range(0, 149) == 0) enable = ~enable;
        rst_n = ($urandom_range(0, 499) != 0);
      end
    end
    enable = 1'b1;
    rst_n  = 1'b1;
    run(10);

    tests = tests + 1;
    if (sbq.size() != 0) begin
      fails = fails + 1;
      $display("FAIL drain: %0d strobes outstanding, required 0", sbq.size());
    end
    tests = tests + 1;
    if (strobes < 20) begin
      fails = fails + 1;
      $display("FAIL strobe_count: %0d strobes seen, required at least 20", strobes);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
